alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 Per requester i in {0,1}: req<i>_valid  input  1  request present.
REQ-006 req<i>_ready  output  1  request accepted this cycle when valid and ready both high.
REQ-007 req<i>_a, req<i>_b  input  DATA_WIDTH  operands (SrcA, SrcB).
REQ-008 req<i>_op  input  OPCODE_LENGTH  ALU operation code.
REQ-009 rsp<i>_valid  output  1  result held for requester i.
REQ-010 rsp<i>_ready  input  1  requester i consumes the result.
REQ-011 rsp<i>_result  output  DATA_WIDTH  registered ALU result.
REQ-012 rsp<i>_err  output  1  opcode was unsupported.
REQ-013 alu_src_a, alu_src_b  output  DATA_WIDTH  to shared ALU.
REQ-014 alu_op  output  OPCODE_LENGTH  to shared ALU.
REQ-015 alu_result  input  DATA_WIDTH  combinational result from shared ALU.

Function
REQ-016 FSM SHALL have states IDLE and EXEC; IDLE -> EXEC on any accepted request; EXEC -> IDLE unconditionally after one cycle.
REQ-017 Requester i SHALL be eligible only when state is IDLE, req<i>_valid=1 and rsp<i>_valid=0 (registered slot state).
REQ-018 Exactly one req<i>_ready SHALL be high per cycle at most; ready may depend combinationally on valid.
REQ-019 One eligible requester: it SHALL be granted; both eligible: grant SHALL go to the requester not granted last (round-robin on last_grant register).
REQ-020 On acceptance, operands, opcode and grant index SHALL be registered; last_grant SHALL update to the granted index.
REQ-021 In EXEC, alu_src_a/alu_src_b/alu_op SHALL be driven from the registered values; in IDLE they SHALL be all zeros.
REQ-022 At the EXEC->IDLE edge, alu_result SHALL be written into rsp<g>_result and rsp<g>_valid set, g = registered grant.
REQ-023 Latency: request accepted at edge N, rsp valid visible after edge N+1; max throughput one op per two cycles.
REQ-024 rsp<i>_valid, rsp<i>_result, rsp<i>_err SHALL hold stable until the cycle rsp<i>_ready=1, then rsp<i>_valid clears at that edge.
REQ-025 Response release and a new request by the same requester in one cycle: the request SHALL NOT be accepted that cycle (slot still full).
REQ-026 A pending response of one requester SHALL NOT block the other requester.
REQ-027 Supported opcodes: 0000,0001,0010,0011,0100,0101,0110,0111,1000,1001,1100,1101; any other SHALL still execute, and rsp<i>_err SHALL be 1 with the returned result (ALU gives 0).
REQ-028 rsp<i>_err SHALL be 0 for supported opcodes.

Reset
REQ-029 With reset_n=0 at a rising edge: state IDLE, last_grant=1 (requester 0 wins first tie), all req<i>_ready=0 during reset, rsp<i>_valid=0, rsp<i>_result=0, rsp<i>_err=0, operand/opcode registers 0.
REQ-030 Reset during EXEC SHALL abort the operation; no response SHALL be produced.
REQ-031 req<i>_ready SHALL be 0 while reset_n=0.

Verification
REQ-032 req0: a=5, b=7, op=0010, ALU adds -> ready0 high one cycle, alu_op=0010 next cycle, rsp0_valid=1, rsp0_result=12, rsp0_err=0 after edge N+1.
REQ-033 Both valid after reset (req0 op 0110 a=9 b=4; req1 op 0000 a=F0 b=3C): req0 granted first (result 5), req1 granted next IDLE (result 0x30); order alternates on repeat.
REQ-034 rsp0_ready held 0, req0 valid again: req0_ready stays 0; req1 requests served meanwhile; rsp0_result stable.
REQ-035 req1 op=1010: rsp1_valid=1, rsp1_result=0, rsp1_err=1.
REQ-036 reset_n=0 during EXEC: after reset no rsp_valid asserted, alu_op=0, next tie grants requester 0.
REQ-037 rsp0_ready=1 and req0_valid=1 same cycle: rsp0_valid clears, request accepted one cycle later.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// One requester channel of the ALU arbiter: a request (operands and opcode)
// going in and a held response coming back.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [DATA_WIDTH-1:0]    req_a;
    logic [DATA_WIDTH-1:0]    req_b;
    logic [OPCODE_LENGTH-1:0] req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_result;
    logic                     rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each requester owns a one-entry response slot; a requester with a full
// slot is not eligible, so a stalled consumer never blocks the other side.
//
// state | meaning
// IDLE  | ALU bus zeroed, arbitration open
// EXEC  | registered operands on ALU bus, result captured at the next edge
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alu_arbiter_if.slave             port0,
    alu_arbiter_if.slave             port1,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     last_grant;
    logic                     grant;
    logic [DATA_WIDTH-1:0]    opnd_a;
    logic [DATA_WIDTH-1:0]    opnd_b;
    logic [OPCODE_LENGTH-1:0] opcode;

    logic [1:0]               rsp_valid_q;
    logic [1:0]               rsp_err_q;
    logic [DATA_WIDTH-1:0]    rsp_result_q [2];

    logic                     elig0;
    logic                     elig1;
    logic                     accept;
    logic                     grant_nxt;
    logic                     op_supported;

    // Eligibility, round-robin choice, next state and ALU bus drive.
    // Ready is gated by reset_n so nothing handshakes while reset is held.
    always_comb begin
        state_nxt     = state;
        elig0         = reset_n && (state == IDLE) && port0.req_valid && !rsp_valid_q[0];
        elig1         = reset_n && (state == IDLE) && port1.req_valid && !rsp_valid_q[1];
        accept        = elig0 || elig1;
        grant_nxt     = (elig0 && elig1) ? ~last_grant : elig1;
        port0.req_ready = accept && !grant_nxt;
        port1.req_ready = accept && grant_nxt;
        alu_src_a     = '0;
        alu_src_b     = '0;
        alu_op        = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = IDLE;
                alu_src_a = opnd_a;
                alu_src_b = opnd_b;
                alu_op    = opcode;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Opcode decode: set when the shared ALU implements the registered opcode.
    always_comb begin
        op_supported = (opcode < OPCODE_LENGTH'(10))
                    || (opcode == OPCODE_LENGTH'(12))
                    || (opcode == OPCODE_LENGTH'(13));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Capture the granted request; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opnd_a     <= '0;
            opnd_b     <= '0;
            opcode     <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            opnd_a     <= grant_nxt ? port1.req_a  : port0.req_a;
            opnd_b     <= grant_nxt ? port1.req_b  : port0.req_b;
            opcode     <= grant_nxt ? port1.req_op : port0.req_op;
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
        end
    end

    // Response slots: release on rsp_ready, fill at the end of EXEC. The slot
    // being filled was empty at acceptance, so release and fill never collide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q     <= '0;
            rsp_err_q       <= '0;
            rsp_result_q[0] <= '0;
            rsp_result_q[1] <= '0;
        end else begin
            if (port0.rsp_ready) rsp_valid_q[0] <= 1'b0;
            if (port1.rsp_ready) rsp_valid_q[1] <= 1'b0;
            if (state == EXEC) begin
                rsp_valid_q[grant]  <= 1'b1;
                rsp_result_q[grant] <= alu_result;
                rsp_err_q[grant]    <= ~op_supported;
            end
        end
    end

    assign port0.rsp_valid  = rsp_valid_q[0];
    assign port0.rsp_result = rsp_result_q[0];
    assign port0.rsp_err    = rsp_err_q[0];
    assign port1.rsp_valid  = rsp_valid_q[1];
    assign port1.rsp_result = rsp_result_q[1];
    assign port1.rsp_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a cycle model of the arbiter
// rules and per-requester queues of expected responses.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] alu_src_a;
    logic [DW-1:0] alu_src_b;
    logic [OL-1:0] alu_op;
    logic [DW-1:0] alu_result;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) p0 ();
    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) p1 ();

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .port0      (p0),
        .port1      (p1),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [OL-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return a << b[4:0];
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return a >> b[4:0];
            4'd9:  return $unsigned($signed(a) >>> b[4:0]);
            4'd12: return ~(a & b);
            4'd13: return b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_src_a, alu_src_b);

    function automatic logic is_bad_op(input logic [OL-1:0] op);
        return op inside {4'd10, 4'd11, 4'd14, 4'd15};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: busy means an operation is on the ALU this cycle.
    logic          m_busy;
    logic          m_g;
    logic          m_last;
    logic [DW-1:0] m_a, m_b;
    logic [OL-1:0] m_op;
    logic          m_full [2];
    logic [DW-1:0] m_res  [2];
    logic          m_err  [2];
    logic [DW:0]   q0 [$];
    logic [DW:0]   q1 [$];

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_last = 1;
        m_a = '0; m_b = '0; m_op = '0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_res[i] = '0; m_err[i] = 0;
        end
        q0.delete(); q1.delete();
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OL-1:0] op);
        if (i == 0) begin
            p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_op = op;
        end else begin
            p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_op = op;
        end
    endtask

    // Compare every output with the model at the negedge, advance the model
    // by the coming edge, then return 1ns after that edge.
    task automatic tick();
        logic          el0, el1, acc, g;
        logic [DW:0]   e;
        @(negedge clk);
        el0 = reset_n && !m_busy && p0.req_valid && !m_full[0];
        el1 = reset_n && !m_busy && p1.req_valid && !m_full[1];
        acc = el0 || el1;
        g   = (el0 && el1) ? ~m_last : el1;
        check_eq("ready0", p0.req_ready, acc && !g);
        check_eq("ready1", p1.req_ready, acc && g);
        check_eq("alu_a",  alu_src_a, m_busy ? m_a  : '0);
        check_eq("alu_b",  alu_src_b, m_busy ? m_b  : '0);
        check_eq("alu_op", alu_op,    m_busy ? m_op : '0);
        check_eq("rsp0_valid",  p0.rsp_valid,  m_full[0]);
        check_eq("rsp1_valid",  p1.rsp_valid,  m_full[1]);
        check_eq("rsp0_result", p0.rsp_result, m_res[0]);
        check_eq("rsp1_result", p1.rsp_result, m_res[1]);
        check_eq("rsp0_err",    p0.rsp_err,    m_err[0]);
        check_eq("rsp1_err",    p1.rsp_err,    m_err[1]);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (p0.rsp_valid && p0.rsp_ready) begin
                if (q0.size() == 0) check_eq("q0_underflow", 1, 0);
                else begin
                    e = q0.pop_front();
                    check_eq("q0_result", {p0.rsp_err, p0.rsp_result}, e);
                end
            end
            if (p1.rsp_valid && p1.rsp_ready) begin
                if (q1.size() == 0) check_eq("q1_underflow", 1, 0);
                else begin
                    e = q1.pop_front();
                    check_eq("q1_result", {p1.rsp_err, p1.rsp_result}, e);
                end
            end
            if (p0.rsp_ready) m_full[0] = 0;
            if (p1.rsp_ready) m_full[1] = 0;
            if (m_busy) begin
                m_full[m_g] = 1;
                m_res[m_g]  = alu_fn(m_op, m_a, m_b);
                m_err[m_g]  = is_bad_op(m_op);
                m_busy      = 0;
            end else if (acc) begin
                m_busy = 1; m_g = g; m_last = g;
                m_a  = g ? p1.req_a  : p0.req_a;
                m_b  = g ? p1.req_b  : p0.req_b;
                m_op = g ? p1.req_op : p0.req_op;
                if (g) q1.push_back({is_bad_op(m_op), alu_fn(m_op, m_a, m_b)});
                else   q0.push_back({is_bad_op(m_op), alu_fn(m_op, m_a, m_b)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0;
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);
        p0.rsp_ready = 0; p1.rsp_ready = 0;
        model_reset();
        #1;
        check_eq("rst_ready0", p0.req_ready, 0);
        repeat (2) tick();
        check_eq("rst_rsp0_valid", p0.rsp_valid, 0);
        check_eq("rst_alu_op", alu_op, 0);
        reset_n = 1;

        // single add on requester 0
        set_req(0, 1, 32'd5, 32'd7, 4'b0010);
        #1 check_eq("d1_ready0", p0.req_ready, 1);
        tick();
        set_req(0, 0, '0, '0, '0);
        check_eq("d1_alu_op", alu_op, 4'b0010);
        tick();
        check_eq("d1_rsp0_valid", p0.rsp_valid, 1);
        check_eq("d1_rsp0_result", p0.rsp_result, 32'd12);
        check_eq("d1_rsp0_err", p0.rsp_err, 0);
        p0.rsp_ready = 1;
        tick();
        check_eq("d1_rsp0_clear", p0.rsp_valid, 0);

        // tie after reset: requester 0 first, then requester 1
        do_reset();
        p0.rsp_ready = 1; p1.rsp_ready = 1;
        set_req(0, 1, 32'd9, 32'd4, 4'b0110);
        set_req(1, 1, 32'hF0, 32'h3C, 4'b0000);
        #1 check_eq("d2_ready0", p0.req_ready, 1);
        check_eq("d2_ready1_low", p1.req_ready, 0);
        tick(); tick();
        check_eq("d2_rsp0_result", p0.rsp_result, 32'd5);
        #1 check_eq("d2_ready1", p1.req_ready, 1);
        tick(); tick();
        check_eq("d2_rsp1_result", p1.rsp_result, 32'h30);
        repeat (8) tick();
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);
        repeat (3) tick();

        // requester 0 stalled on its response; requester 1 keeps going
        p0.rsp_ready = 0;
        set_req(0, 1, 32'd100, 32'd1, 4'b0010);
        tick(); tick();
        check_eq("d3_rsp0_result", p0.rsp_result, 32'd101);
        set_req(1, 1, 32'd3, 32'd3, 4'b0010);
        repeat (6) begin
            #1 check_eq("d3_ready0_low", p0.req_ready, 0);
            tick();
        end
        check_eq("d3_rsp0_stable", p0.rsp_result, 32'd101);
        check_eq("d3_rsp1_result", p1.rsp_result, 32'd6);
        set_req(1, 0, '0, '0, '0);

        // release and re-request in the same cycle
        p0.rsp_ready = 1;
        #1 check_eq("d4_ready0_blocked", p0.req_ready, 0);
        tick();
        check_eq("d4_rsp0_cleared", p0.rsp_valid, 0);
        #1 check_eq("d4_ready0_now", p0.req_ready, 1);
        tick();
        set_req(0, 0, '0, '0, '0);
        repeat (3) tick();

        // unsupported opcode
        p1.rsp_ready = 0;
        set_req(1, 1, 32'h1234, 32'h55, 4'b1010);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();
        check_eq("d5_rsp1_valid", p1.rsp_valid, 1);
        check_eq("d5_rsp1_result", p1.rsp_result, 0);
        check_eq("d5_rsp1_err", p1.rsp_err, 1);
        p1.rsp_ready = 1;
        tick();

        // reset during EXEC aborts the operation
        set_req(1, 1, 32'd8, 32'd2, 4'b0010);
        tick();
        set_req(1, 0, '0, '0, '0);
        check_eq("d6_in_exec", alu_op, 4'b0010);
        reset_n = 0;
        tick();
        reset_n = 1;
        check_eq("d6_no_rsp1", p1.rsp_valid, 0);
        check_eq("d6_alu_op0", alu_op, 0);
        set_req(0, 1, 32'd1, 32'd1, 4'b0000);
        set_req(1, 1, 32'd1, 32'd1, 4'b0000);
        #1 check_eq("d6_tie_ready0", p0.req_ready, 1);
        tick(); tick();
        check_eq("d6_no_rsp1_late", p1.rsp_valid, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < 2; i++)
                set_req(i, $urandom_range(0, 9) < 6, $urandom, $urandom,
                        ($urandom_range(0, 7) == 0) ? OL'($urandom_range(10, 15))
                                                    : OL'($urandom_range(0, 15)));
            p0.rsp_ready = $urandom_range(0, 1);
            p1.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
